// File: rtl/icache_refill_unit.sv
// Refills one L1 instruction-cache block from a 64-bit memory port, one beat at a time.
// Optional build macro REFILL_CRITICAL_FIRST_EN: start at the missing beat and wrap.
module icache_refill_unit #(
  parameter int SIZE_PC     = 32,
  parameter int CACHE_WIDTH = 256,
  parameter int MEM_WIDTH   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   miss_i,
  input  logic [SIZE_PC-1:0]     missAddr_i,
  input  logic                   abort_i,
  output logic                   memReq_o,
  output logic [SIZE_PC-1:0]     memAddr_o,
  input  logic                   memGnt_i,
  input  logic                   memValid_i,
  input  logic [MEM_WIDTH-1:0]   memData_i,
  output logic                   wrEnable_o,
  output logic [SIZE_PC-1:0]     wrAddr_o,
  output logic [CACHE_WIDTH-1:0] instBlock_o,
  output logic                   busy_o
);

  localparam int BEATS     = CACHE_WIDTH / MEM_WIDTH;
  localparam int BEAT_BITS = $clog2(BEATS);
  localparam int BYTE_BITS = $clog2(MEM_WIDTH / 8);
  localparam int OFFS_BITS = BEAT_BITS + BYTE_BITS;
  localparam logic [BEAT_BITS:0] LAST_COUNT = (BEAT_BITS+1)'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, COOL} state_t;

  state_t                      stateReg, stateNext;
  logic [SIZE_PC-OFFS_BITS-1:0] baseReg, baseNext;
  logic [BEAT_BITS-1:0]        beatIdxReg, beatIdxNext;
  logic [BEAT_BITS:0]          countReg, countNext;
  logic                        discardReg, discardNext;
  logic [CACHE_WIDTH-1:0]      bufferReg, bufferNext;
  logic [CACHE_WIDTH-1:0]      instBlockReg;
  logic [SIZE_PC-1:0]          wrAddrReg;
  logic                        busyReg;
  logic                        beatWe;
  logic [BEAT_BITS-1:0]        startBeat;
  logic                        unusedAddrBits;

`ifdef REFILL_CRITICAL_FIRST_EN
  assign startBeat = missAddr_i[OFFS_BITS-1:BYTE_BITS];
`else
  assign startBeat = '0;
`endif

  assign unusedAddrBits = ^missAddr_i[OFFS_BITS-1:0];

  always_comb begin
    stateNext   = stateReg;
    baseNext    = baseReg;
    beatIdxNext = beatIdxReg;
    countNext   = countReg;
    discardNext = discardReg;
    beatWe      = 1'b0;
    case (stateReg)
      IDLE: begin
        if (miss_i && !abort_i) begin
          stateNext   = ISSUE;
          baseNext    = missAddr_i[SIZE_PC-1:OFFS_BITS];
          beatIdxNext = startBeat;
          countNext   = '0;
          discardNext = 1'b0;
        end
      end
      ISSUE: begin
        // A grant in the abort cycle still leaves a response in flight, so drain it.
        if (memGnt_i) begin
          stateNext   = WAIT;
          discardNext = abort_i;
        end else if (abort_i) begin
          stateNext = IDLE;
        end
      end
      WAIT: begin
        if (abort_i) discardNext = 1'b1;
        if (memValid_i) begin
          if (discardReg || abort_i) begin
            stateNext   = IDLE;
            discardNext = 1'b0;
          end else begin
            beatWe      = 1'b1;
            beatIdxNext = beatIdxReg + 1'b1;
            countNext   = countReg + 1'b1;
            stateNext   = (countReg == LAST_COUNT) ? WRITE : ISSUE;
          end
        end
      end
      WRITE:   stateNext = COOL;
      COOL:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Slot placement is by address, independent of request order.
  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : gSlot
      assign bufferNext[gi*MEM_WIDTH +: MEM_WIDTH] =
        (beatWe && beatIdxReg == BEAT_BITS'(gi)) ? memData_i
                                                 : bufferReg[gi*MEM_WIDTH +: MEM_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg     <= IDLE;
      baseReg      <= '0;
      beatIdxReg   <= '0;
      countReg     <= '0;
      discardReg   <= 1'b0;
      bufferReg    <= '0;
      instBlockReg <= '0;
      wrAddrReg    <= '0;
      busyReg      <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      baseReg    <= baseNext;
      beatIdxReg <= beatIdxNext;
      countReg   <= countNext;
      discardReg <= discardNext;
      bufferReg  <= bufferNext;
      busyReg    <= (stateNext != IDLE);
      // Output copy keeps the last block stable while the next refill fills bufferReg.
      if (stateNext == WRITE) begin
        instBlockReg <= bufferNext;
        wrAddrReg    <= {baseReg, {OFFS_BITS{1'b0}}};
      end
    end
  end

  assign memReq_o    = (stateReg == ISSUE);
  assign memAddr_o   = (stateReg == ISSUE) ? {baseReg, beatIdxReg, {BYTE_BITS{1'b0}}} : '0;
  assign wrEnable_o  = (stateReg == WRITE);
  assign wrAddr_o    = wrAddrReg;
  assign instBlock_o = instBlockReg;
  assign busy_o      = busyReg;

endmodule

// File: tb/tb_icache_refill_unit.sv
// Directed bench for icache_refill_unit: memory responder with programmable grant and
// response delays, request-order / block-content / latency / abort checks.
module tb_icache_refill_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic         miss_i;
  logic [31:0]  missAddr_i;
  logic         abort_i;
  logic         memReq_o;
  logic [31:0]  memAddr_o;
  logic         memGnt_i;
  logic         memValid_i;
  logic [63:0]  memData_i;
  logic         wrEnable_o;
  logic [31:0]  wrAddr_o;
  logic [255:0] instBlock_o;
  logic         busy_o;

  int checks = 0;
  int errors = 0;

  int gntDelay = 0, rspDelay = 0, gntCnt = 0, rspCnt = 0;
  bit pending = 0, waiting = 0;
  logic [31:0] pendAddr, holdAddr;
  logic [31:0] reqLog[$];
  int wrCount = 0;

  icache_refill_unit dut (
    .clk(clk), .reset(reset), .miss_i(miss_i), .missAddr_i(missAddr_i),
    .abort_i(abort_i), .memReq_o(memReq_o), .memAddr_o(memAddr_o),
    .memGnt_i(memGnt_i), .memValid_i(memValid_i), .memData_i(memData_i),
    .wrEnable_o(wrEnable_o), .wrAddr_o(wrAddr_o), .instBlock_o(instBlock_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] memWord(input logic [31:0] a);
    logic [31:0] lo;
    lo = 32'hA0 + {30'b0, a[4:3]};
    return {a, lo};
  endfunction

  // Memory responder: one outstanding request, inputs changed on the falling edge.
  initial begin
    memGnt_i = 0; memValid_i = 0; memData_i = 64'hDEAD_BEEF_DEAD_BEEF;
    forever begin
      @(negedge clk);
      memGnt_i = 0; memValid_i = 0; memData_i = 64'hDEAD_BEEF_DEAD_BEEF;
      if (pending) begin
        if (rspCnt == 0) begin
          memValid_i = 1; memData_i = memWord(pendAddr); pending = 0;
        end else rspCnt--;
      end else if (memReq_o) begin
        if (!waiting) begin waiting = 1; holdAddr = memAddr_o; end
        else checkVal("addr_stable", {224'b0, memAddr_o}, {224'b0, holdAddr});
        if (gntCnt == 0) begin
          memGnt_i = 1; reqLog.push_back(memAddr_o);
          pending = 1; pendAddr = memAddr_o; rspCnt = rspDelay;
          gntCnt = gntDelay; waiting = 0;
        end else gntCnt--;
      end else waiting = 0;
    end
  end

  always @(negedge clk) if (wrEnable_o) wrCount++;

  task automatic setMem(input int g, input int r);
    gntDelay = g; gntCnt = g; rspDelay = r;
    reqLog.delete();
  endtask

  task automatic runRefill(input logic [31:0] addr, input int g, input int r,
                           input bit holdMiss, input bit checkLat);
    logic [31:0]  base, expA;
    logic [255:0] expBlk;
    int start, cyc, wrCyc, idleCyc, wrBase, reqHigh;
    bit done;
    base = addr & ~32'h1F;
`ifdef REFILL_CRITICAL_FIRST_EN
    start = int'(addr[4:3]);
`else
    start = 0;
`endif
    for (int k = 0; k < 4; k++) expBlk[64*k +: 64] = memWord(base + 32'(8*k));
    setMem(g, r);
    wrBase = wrCount;
    @(negedge clk); missAddr_i = addr; miss_i = 1;
    cyc = 0; wrCyc = 0; idleCyc = 0; done = 0;
    while (!done && cyc < 400) begin
      @(negedge clk); #1; cyc++;
      if (cyc == 1) begin
        checkVal("req_next_cycle", {255'b0, memReq_o}, 256'd1);
        checkVal("busy_next_cycle", {255'b0, busy_o}, 256'd1);
      end
      if (wrEnable_o && wrCyc == 0) begin
        wrCyc = cyc;
        checkVal("wr_addr", {224'b0, wrAddr_o}, {224'b0, base});
        checkVal("wr_block", instBlock_o, expBlk);
        if (!holdMiss) miss_i = 0;
      end else if (wrCyc != 0 && !busy_o) begin
        done = 1; idleCyc = cyc;
        if (holdMiss) miss_i = 0;
      end
    end
    checkVal("refill_done", {255'b0, done}, 256'd1);
    miss_i = 0;
    checkVal("req_count", 256'(reqLog.size()), 256'd4);
    for (int k = 0; k < reqLog.size() && k < 4; k++) begin
      expA = base + 32'(8 * ((start + k) % 4));
      checkVal($sformatf("req_addr%0d", k), {224'b0, reqLog[k]}, {224'b0, expA});
    end
    if (checkLat) begin
      checkVal("write_latency", 256'(wrCyc), 256'd9);
      checkVal("idle_latency", 256'(idleCyc), 256'd11);
    end
    reqHigh = 0;
    repeat (5) begin @(negedge clk); #1; if (memReq_o || busy_o) reqHigh++; end
    checkVal("no_rerefill", 256'(reqHigh), 256'd0);
    checkVal("one_write", 256'(wrCount - wrBase), 256'd1);
    checkVal("block_held", instBlock_o, expBlk);
    $display("refill addr %h base %h writes %0d wrCyc %0d", addr, base, wrCount - wrBase, wrCyc);
  endtask

  initial begin
    int n, quiet, wrBase;
    reset = 1; miss_i = 0; missAddr_i = 0; abort_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 0;
    #1;
    checkVal("rst_memReq", {255'b0, memReq_o}, 256'd0);
    checkVal("rst_wrEnable", {255'b0, wrEnable_o}, 256'd0);
    checkVal("rst_busy", {255'b0, busy_o}, 256'd0);
    checkVal("rst_memAddr", {224'b0, memAddr_o}, 256'd0);
    checkVal("rst_wrAddr", {224'b0, wrAddr_o}, 256'd0);
    checkVal("rst_block", instBlock_o, 256'd0);
    quiet = 0;
    repeat (10) begin @(negedge clk); #1; if (memReq_o || busy_o || wrEnable_o) quiet++; end
    checkVal("idle_quiet", 256'(quiet), 256'd0);
    $display("reset/idle done");

    runRefill(32'h0000_1040, 0, 0, 0, 1);
    runRefill(32'h0000_1018, 0, 0, 1, 1);   // miss held through WRITE and COOL
    runRefill(32'h0000_5564, 3, 5, 0, 0);

    // Abort while waiting for beat 1's response.
    setMem(0, 3);
    wrBase = wrCount;
    @(negedge clk); missAddr_i = 32'h0000_3000; miss_i = 1;
    n = 0;
    while (reqLog.size() < 2 && n < 100) begin @(negedge clk); #1; n++; end
    @(negedge clk); abort_i = 1; miss_i = 0;
    @(negedge clk); abort_i = 0;
    n = 0;
    while (!memValid_i && n < 100) begin @(negedge clk); #1; n++; end
    checkVal("abort_rsp_seen", {255'b0, memValid_i}, 256'd1);
    checkVal("abort_busy_during_rsp", {255'b0, busy_o}, 256'd1);
    @(negedge clk); #1;
    checkVal("abort_idle", {255'b0, busy_o}, 256'd0);
    repeat (8) @(negedge clk);
    checkVal("abort_no_write", 256'(wrCount - wrBase), 256'd0);
    checkVal("abort_req_count", 256'(reqLog.size()), 256'd2);
    $display("abort in WAIT: requests %0d writes %0d", reqLog.size(), wrCount - wrBase);

    // Abort in ISSUE before any grant.
    setMem(6, 0);
    @(negedge clk); missAddr_i = 32'h0000_4000; miss_i = 1;
    @(negedge clk); abort_i = 1; miss_i = 0;
    @(negedge clk); #1; abort_i = 0;
    checkVal("abort_issue_busy", {255'b0, busy_o}, 256'd0);
    checkVal("abort_issue_req", {255'b0, memReq_o}, 256'd0);
    repeat (3) @(negedge clk);
    checkVal("abort_issue_nogrant", 256'(reqLog.size()), 256'd0);
    $display("abort in ISSUE: requests %0d", reqLog.size());

    runRefill(32'h0000_2000, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
